// File: rtl/hilo_muldiv_unit.sv
// HI/LO register file with an iterative multiply/divide engine and a hazard stall for HI/LO instructions.
// Optional macro HILO_FAST_MUL_EN: single-cycle multiply; divide stays iterative.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_valid,
  input  logic [2:0]       HiLotype,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [WIDTH-1:0] hilo_rdata,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  localparam logic [2:0] HL_NONE   = 3'b000;
  localparam logic [2:0] HL_MTHI   = 3'b101;
  localparam logic [2:0] HL_MTLO   = 3'b011;
  localparam logic [2:0] HL_MFHI   = 3'b100;
  localparam logic [2:0] HL_MFLO   = 3'b010;
  localparam logic [2:0] HL_MULDIV = 3'b111;

  state_e               state_q;
  logic [WIDTH-1:0]     hi_q, lo_q, op_b_q;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 is_div_q, neg_res_q, neg_rem_q;
  logic                 busy_q, done_q, div_zero_q;

  logic                 accept, start, rs_neg, rt_neg, funct_unused;
  logic [WIDTH-1:0]     rs_mag, rt_mag, quo_fix, rem_fix;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH:0]       add_sum, rem_shift, rem_diff;

  assign stall  = inst_valid & busy_q & (HiLotype != HL_NONE);
  assign accept = inst_valid & ~stall;
  assign start  = accept & (HiLotype == HL_MULDIV);

  // funct[0] selects unsigned; only the low two bits matter here.
  assign rs_neg = ~funct[0] & rs_data[WIDTH-1];
  assign rt_neg = ~funct[0] & rt_data[WIDTH-1];
  assign rs_mag = rs_neg ? -rs_data : rs_data;
  assign rt_mag = rt_neg ? -rt_data : rt_data;
  assign funct_unused = ^funct[5:2];

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    hilo_rdata = '0;
    if (accept && HiLotype == HL_MFHI)      hilo_rdata = hi_q;
    else if (accept && HiLotype == HL_MFLO) hilo_rdata = lo_q;
  end

  // acc_q = {upper, lower}: multiply keeps {partial product, remaining multiplier};
  // divide keeps {partial remainder, dividend bits shifting into quotient bits}.
  always_comb begin
    add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, op_b_q & {WIDTH{acc_q[0]}}};
    rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
    rem_diff  = rem_shift - {1'b0, op_b_q};
    if (!is_div_q)          acc_d = {add_sum, acc_q[WIDTH-1:1]};
    else if (!rem_diff[WIDTH]) acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else                    acc_d = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  end

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

`ifdef HILO_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_mag, fast_prod;
  assign fast_mag  = {{WIDTH{1'b0}}, rs_mag} * {{WIDTH{1'b0}}, rt_mag};
  assign fast_prod = (rs_neg ^ rt_neg) ? -fast_mag : fast_mag;
`endif

  // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      op_b_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      if (accept && HiLotype == HL_MTHI) hi_q <= rs_data;
      if (accept && HiLotype == HL_MTLO) lo_q <= rs_data;

      case (state_q)
        IDLE: begin
          if (start) begin
            if (funct[1] && rt_data == '0) begin
              done_q     <= 1'b1;
              div_zero_q <= 1'b1;
            end
`ifdef HILO_FAST_MUL_EN
            else if (!funct[1]) begin
              {hi_q, lo_q} <= fast_prod;
              done_q       <= 1'b1;
            end
`endif
            else begin
              state_q   <= RUN;
              busy_q    <= 1'b1;
              acc_q     <= {{WIDTH{1'b0}}, rs_mag};
              op_b_q    <= rt_mag;
              cnt_q     <= '0;
              is_div_q  <= funct[1];
              neg_res_q <= rs_neg ^ rt_neg;
              neg_rem_q <= rs_neg;
            end
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= FIN;
        end
        FIN: begin
          if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: HI/LO moves, iterative mul/div, divide-by-zero, hazards, mid-op reset.
module tb_hilo_muldiv_unit;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [2:0] T_NONE  = 3'b000;
  localparam logic [2:0] T_MTHI  = 3'b101;
  localparam logic [2:0] T_MTLO  = 3'b011;
  localparam logic [2:0] T_MFHI  = 3'b100;
  localparam logic [2:0] T_MFLO  = 3'b010;
  localparam logic [2:0] T_MD    = 3'b111;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_valid;
  logic [2:0]  HiLotype;
  logic [5:0]  funct;
  logic [31:0] rs_data, rt_data;
  logic [31:0] hilo_rdata, hi, lo;
  logic        stall, busy, done, div_zero;

  int checks = 0;
  int errors = 0;
  int n;

  hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .inst_valid (inst_valid),
    .HiLotype   (HiLotype),
    .funct      (funct),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .hilo_rdata (hilo_rdata),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] t, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    inst_valid = 1'b1;
    HiLotype   = t;
    funct      = f;
    rs_data    = a;
    rt_data    = b;
    #1;
  endtask

  task automatic idle();
    inst_valid = 1'b0;
    HiLotype   = T_NONE;
    funct      = 6'h00;
  endtask

  // Issue one mul/div and follow it to completion: 33 busy cycles, then done with the result.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc = 0;
    issue(T_MD, f, a, b);
    tick();
    idle();
    while (busy && cyc < 100) begin
      cyc++;
      tick();
    end
    checkn({tag, " busy_cycles"}, cyc, 33);
    check1({tag, " done"}, done, 1'b1);
    check1({tag, " div_zero"}, div_zero, 1'b0);
    check32({tag, " hi"}, hi, exp_hi);
    check32({tag, " lo"}, lo, exp_lo);
    tick();
    check1({tag, " done_clear"}, done, 1'b0);
  endtask

  initial begin
    reset   = 1'b0;
    rs_data = 32'h0;
    rt_data = 32'h0;
    idle();
    tick();
    tick();
    reset = 1'b1;
    #1;
    check32("rst hi", hi, 32'h0);
    check32("rst lo", lo, 32'h0);
    check1("rst busy", busy, 1'b0);
    check1("rst stall", stall, 1'b0);
    check1("rst done", done, 1'b0);
    check32("rst rdata", hilo_rdata, 32'h0);

    // mthi then mfhi; mtlo then mflo
    issue(T_MTHI, 6'h00, 32'h12345678, 32'h0);
    tick();
    check32("mthi hi", hi, 32'h12345678);
    issue(T_MFHI, 6'h00, 32'h0, 32'h0);
    check32("mfhi rdata", hilo_rdata, 32'h12345678);
    check1("mfhi stall", stall, 1'b0);
    check32("mthi lo untouched", lo, 32'h0);
    issue(T_MTLO, 6'h00, 32'hCAFEF00D, 32'h0);
    tick();
    issue(T_MFLO, 6'h00, 32'h0, 32'h0);
    check32("mflo rdata", hilo_rdata, 32'hCAFEF00D);
    check32("mtlo hi untouched", hi, 32'h12345678);
    idle();
    #1;
    check32("idle rdata", hilo_rdata, 32'h0);
    tick();

    // iterative multiply / divide, including the signed overflow case
    run_op("mult 7*-3", F_MULT, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("multu max*max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("div -7/2", F_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);

    // divide by zero: immediate done + div_zero, no busy, HI/LO kept
    issue(T_MD, F_DIVU, 32'h00000005, 32'h0);
    tick();
    idle();
    check1("divz done", done, 1'b1);
    check1("divz flag", div_zero, 1'b1);
    check1("divz busy", busy, 1'b0);
    check32("divz hi", hi, 32'hFFFFFFFF);
    check32("divz lo", lo, 32'hFFFFFFFD);
    tick();
    check1("divz done_clear", done, 1'b0);
    check1("divz flag_clear", div_zero, 1'b0);
    check1("divz busy_after", busy, 1'b0);

    run_op("div min/-1", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // hazards while a multiply is in flight
    issue(T_MD, F_MULT, 32'h00000003, 32'h00000005);
    tick();
    issue(T_NONE, 6'h20, 32'h1, 32'h2);
    check1("add no stall", stall, 1'b0);
    check1("add busy", busy, 1'b1);
    tick();
    issue(T_MD, F_MULTU, 32'h9, 32'h9);
    check1("muldiv while busy stall", stall, 1'b1);
    tick();
    issue(T_MFLO, 6'h00, 32'h0, 32'h0);
    check1("mflo stall", stall, 1'b1);
    check32("mflo stalled rdata", hilo_rdata, 32'h0);
    n = 0;
    while (stall && n < 100) begin
      tick();
      n++;
    end
    checkn("mflo stall cycles", n, 31);
    check32("mflo new lo", hilo_rdata, 32'h0000000F);
    check32("hazard mult hi", hi, 32'h0);
    check1("hazard done", done, 1'b1);
    idle();
    tick();
    check1("no queued op", busy, 1'b0);

    // reset during iteration 10 of a divide
    issue(T_MD, F_DIVU, 32'd100, 32'd7);
    tick();
    idle();
    repeat (10) tick();
    check1("pre-reset busy", busy, 1'b1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check1("abort busy", busy, 1'b0);
    check32("abort hi", hi, 32'h0);
    check32("abort lo", lo, 32'h0);
    check1("abort done", done, 1'b0);
    tick();
    check1("abort no done", done, 1'b0);
    check1("abort still idle", busy, 1'b0);

    run_op("mult -1*min", F_MULT, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32'h80000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Consumer of the control unit's HiLotype/funct decode.
- Owns the HI/LO architectural registers.
- Executes mult/multu/div/divu iteratively in WIDTH cycles.
- Services mthi/mtlo/mfhi/mflo and asserts stall to the single-cycle datapath on HI/LO hazards while an operation is in flight.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count for mul/div.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low
inst_valid  in  1  decoded instruction present this cycle
HiLotype  in  3  {hi_sel, lo_sel, write}: 101 mthi, 011 mtlo, 100 mfhi, 010 mflo, 111 mul/div, 000 none
funct  in  6  inst[5:0]; bit1=1 divide, bit0=1 unsigned (valid when HiLotype=111)
rs_data  in  WIDTH  rs operand / mthi-mtlo source
rt_data  in  WIDTH  rt operand
hilo_rdata  out  WIDTH  HI (mfhi) or LO (mflo), else 0; combinational
stall  out  1  hold PC/inhibit commit this cycle
busy  out  1  mul/div in progress
done  out  1  one-cycle pulse when HI/LO updated by mul/div
div_zero  out  1  pulses with done when divisor was 0
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (reset==0 at edge) has top priority and aborts any operation. HI, LO, internal regs and counter go to 0; busy, done and div_zero go to 0.
- stall = inst_valid & busy & (HiLotype != 000). Combinational. Non-HI/LO instructions never stall.
- accept = inst_valid & ~stall.
- mthi/mtlo: on the accept edge, HI or LO <= rs_data. Other register unchanged.
- mfhi/mflo: hilo_rdata = HI or LO when accepted. A stalled read is retried by the datapath; no bypass needed.
- FSM states: IDLE, RUN, FIN.
  - IDLE -> RUN: on accept with HiLotype=111 and divisor nonzero (or multiply).
    - Latch |rs|, |rt| (magnitude unless unsigned).
    - Latch result sign and dividend sign.
    - Clear the accumulator; counter <= 0; busy <= 1.
  - RUN: one iteration per cycle.
    - Multiply: shift-add into a 2*WIDTH product.
    - Divide: restoring, one quotient bit per cycle.
    - counter increments each cycle; after WIDTH iterations (counter==WIDTH-1) -> FIN.
  - FIN (one cycle):
    - Apply sign correction and write HI/LO at the edge leaving FIN.
    - busy <= 0; done <= 1 for exactly the following cycle.
- Timing: busy is high for WIDTH+1 cycles after the start edge. HI/LO are valid on the first cycle with busy=0.
- Multiply result: {HI,LO} = product. Signed: two's-complement negate if operand signs differ.
- Divide result: LO = quotient, HI = remainder.
  - Quotient is negated if signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / -1 (signed): LO = 0x80000000, HI = 0. No trap.
- Divide by zero:
  - No RUN; busy stays 0.
  - HI/LO unchanged.
  - done and div_zero pulse on the next cycle.
- Mul/div issued while busy: stalled. No queueing, no abort of the running operation.
- mthi/mtlo and the write of a finishing operation never collide, because HI/LO instructions stall while busy.
- inst_valid=0: no state change except RUN/FIN progression.

Optional Feature:
- Macro HILO_FAST_MUL_EN.
- Defined:
  - mult/multu compute the full product combinationally and write HI/LO on the accept edge.
  - busy never asserts for multiply.
  - done pulses the next cycle.
  - Divide is unchanged (iterative).
- Undefined: multiply uses the WIDTH+1 cycle iterative path described above.

Test Plan:
- Reset low 2 cycles, then high -> HI=LO=0, busy=stall=done=0, hilo_rdata=0.
- mthi rs=0x12345678, next cycle mfhi -> hilo_rdata=0x12345678; LO still 0; no stall.
- mult rs=7, rt=0xFFFFFFFD -> busy for 33 cycles, done pulse; HI=0xFFFFFFFF, LO=0xFFFFFFEB. multu 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- div rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu rs=5, rt=0 -> div_zero+done next cycle, busy never 1, HI/LO unchanged.
- mflo issued 3 cycles after mult start -> stall high until busy falls; accepted read returns the new LO; an add issued while busy -> stall=0.
- reset low at iteration 10 of a divide -> next cycle busy=0, HI=LO=0, no done pulse; a new mult then completes normally.
